// File: rtl/cfg_frame_decoder.sv
// cfg_frame_decoder
// Turns SPI byte frames into 32-bit configuration register writes and read-backs.
// A frame is a command byte followed by four data bytes, sent MSB first.
// Command byte: bit7 = write (1) or read (0); bits[ADDR_W-1:0] = register address.
// Writes land in a pending bank. The active bank drives cfg_out.
// With SHADOW=1 the active bank copies dirty pending registers on frame_sync.
// With SHADOW=0 the active bank is written together with the pending bank.
//
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   cs_n         SPI select (already synchronised); low while a frame is in progress
//   rx_valid     one-cycle strobe; rx_byte holds a received byte
//   rx_byte      received byte
//   frame_sync   one-cycle pulse at the start of vertical sync
//   tx_byte      next byte for the SPI transmitter, valid while tx_load is high
//   tx_load      one-cycle strobe for tx_byte
//   cfg_out      active bank; register k occupies bits [32k+31:32k]
//   cfg_update   one-cycle pulse whenever cfg_out is reloaded
//   busy         high while a frame is being handled (any state but idle)
//   err_count    saturating count of aborted or invalid frames
module cfg_frame_decoder #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = 2,
  parameter bit          SHADOW   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs_n,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_byte,
  input  logic                     frame_sync,
  output logic [7:0]               tx_byte,
  output logic                     tx_load,
  output logic [32*NUM_REGS-1:0]   cfg_out,
  output logic                     cfg_update,
  output logic                     busy,
  output logic [7:0]               err_count
);

  typedef enum logic [2:0] {StIdle, StWdata, StRdata, StDone, StIgnore} state_e;

  state_e state_q, state_d;

  logic [NUM_REGS-1:0][31:0] pending_q, pending_d;
  logic [NUM_REGS-1:0][31:0] active_q, active_d;
  logic [NUM_REGS-1:0]       dirty_q, dirty_d;
  logic [31:0]               asm_q, asm_d;
  logic [31:0]               rd_shift_q, rd_shift_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [1:0]                idx_q, idx_d;
  logic [7:0]                tx_byte_q, tx_byte_d;
  logic                      tx_load_q, tx_load_d;
  logic                      cfg_update_q, cfg_update_d;
  logic                      busy_q, busy_d;
  logic [7:0]                err_q, err_d;

  logic              rx_take;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_valid;
  logic              last_byte;
  logic              data_take;
  logic [31:0]       rd_word;
  logic [31:0]       asm_word;
  logic              commit;
  logic              err_inc;

  // Reserved command bits carry no meaning.
  logic unused_rsvd;
  assign unused_rsvd = ^rx_byte[6:ADDR_W];

  assign rx_take   = rx_valid & ~cs_n;
  assign cmd_write = rx_byte[7];
  assign cmd_addr  = rx_byte[ADDR_W-1:0];
  assign cmd_valid = 32'(cmd_addr) < NUM_REGS;
  assign asm_word  = {asm_q[23:0], rx_byte};
  // The last data byte still counts when cs_n rises in the same cycle,
  // so a frame that ends exactly on time is not treated as aborted.
  assign last_byte = rx_valid & (idx_q == 2'd3);
  assign data_take = rx_take | last_byte;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (cmd_addr == ADDR_W'(k)) rd_word = pending_q[k];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rx_take) begin
          if (!cmd_valid)     state_d = StIgnore;
          else if (cmd_write) state_d = StWdata;
          else                state_d = StRdata;
        end
      end
      StWdata, StRdata: begin
        if (last_byte)  state_d = cs_n ? StIdle : StDone;
        else if (cs_n)  state_d = StIdle;
      end
      StDone, StIgnore: begin
        if (cs_n) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    pending_d    = pending_q;
    active_d     = active_q;
    dirty_d      = dirty_q;
    asm_d        = asm_q;
    rd_shift_d   = rd_shift_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    tx_byte_d    = tx_byte_q;
    tx_load_d    = 1'b0;
    cfg_update_d = 1'b0;
    commit       = 1'b0;
    err_inc      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_take) begin
          idx_d  = 2'd0;
          addr_d = cmd_addr;
          if (!cmd_valid) begin
            err_inc = 1'b1;
          end else if (!cmd_write) begin
            rd_shift_d = rd_word;
            tx_byte_d  = rd_word[31:24];
            tx_load_d  = 1'b1;
          end
        end
      end
      StWdata: begin
        if (data_take) begin
          asm_d = asm_word;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) commit = 1'b1;
        end else if (cs_n) begin
          err_inc = 1'b1;
        end
      end
      StRdata: begin
        if (data_take) begin
          idx_d = idx_q + 2'd1;
          // The fourth dummy byte only closes the frame; nothing left to send.
          if (idx_q != 2'd3) begin
            rd_shift_d = {rd_shift_q[23:0], 8'h00};
            tx_byte_d  = rd_shift_q[23:16];
            tx_load_d  = 1'b1;
          end
        end else if (cs_n) begin
          err_inc = 1'b1;
        end
      end
      default: ;
    endcase

    // The frame_sync copy is evaluated from the pre-edge bank, before a commit
    // in the same cycle marks its register dirty again.
    if (SHADOW && frame_sync) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (dirty_q[k]) begin
          active_d[k] = pending_q[k];
          dirty_d[k]  = 1'b0;
        end
      end
      cfg_update_d = |dirty_q;
    end

    if (commit) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (addr_q == ADDR_W'(k)) begin
          pending_d[k] = asm_word;
          if (SHADOW) dirty_d[k]  = 1'b1;
          else        active_d[k] = asm_word;
        end
      end
      if (!SHADOW) cfg_update_d = 1'b1;
    end

    err_d  = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    busy_d = (state_d != StIdle);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      active_q     <= '0;
      dirty_q      <= '0;
      asm_q        <= '0;
      rd_shift_q   <= '0;
      addr_q       <= '0;
      idx_q        <= '0;
      tx_byte_q    <= '0;
      tx_load_q    <= 1'b0;
      cfg_update_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      pending_q    <= pending_d;
      active_q     <= active_d;
      dirty_q      <= dirty_d;
      asm_q        <= asm_d;
      rd_shift_q   <= rd_shift_d;
      addr_q       <= addr_d;
      idx_q        <= idx_d;
      tx_byte_q    <= tx_byte_d;
      tx_load_q    <= tx_load_d;
      cfg_update_q <= cfg_update_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign cfg_out    = active_q;
  assign tx_byte    = tx_byte_q;
  assign tx_load    = tx_load_q;
  assign cfg_update = cfg_update_q;
  assign busy       = busy_q;
  assign err_count  = err_q;

endmodule

// File: doc/cfg_frame_decoder.md
# cfg_frame_decoder

Byte-level command decoder that sits directly downstream of the SPI peripheral and upstream of the pixel multiplexer. It assembles SPI byte frames into 32-bit configuration words, holds them in a small register bank, and serves register read-back bytes to the SPI transmit path. With SHADOW=1, written values become visible on `cfg_out` only at a video frame boundary, so the pixel mux never changes source or colour mid-frame.

## Interface
Parameters:
- NUM_REGS, 4: number of 32-bit configuration registers (1..4).
- ADDR_W, 2: width of the command address field.
- SHADOW, 1: 1 = active bank updates on `frame_sync`; 0 = active bank updates immediately on commit.

Ports:
- clk  in  1  system clock; the only clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- cs_n  in  1  SPI select, already synchronised to `clk`; low while a frame is in progress.
- rx_valid  in  1  one-cycle strobe: `rx_byte` holds a complete received byte.
- rx_byte  in  8  received byte.
- frame_sync  in  1  one-cycle pulse at start of vertical sync.
- tx_byte  out  8  next byte for the SPI peripheral to shift out.
- tx_load  out  1  one-cycle strobe: `tx_byte` is valid.
- cfg_out  out  32*NUM_REGS  active bank; register k occupies bits [32k+31:32k].
- cfg_update  out  1  one-cycle pulse whenever `cfg_out` changes.
- busy  out  1  high in any state other than IDLE.
- err_count  out  8  saturating count of aborted or invalid frames.

## Operation
- Frame layout: command byte, then 4 data bytes, MSB first.
- Command byte fields:
  - bit7 = 1 write, 0 read.
  - bits[ADDR_W-1:0] = register address.
  - Remaining bits are reserved and ignored.
- States:
  - IDLE: waits for cs_n low and rx_valid; the byte is taken as a command.
  - WDATA: collects data bytes for a write.
  - RDATA: serves read-back bytes.
  - DONE: frame complete.
  - IGNORE: invalid command.
- IDLE → WDATA on a write command. Byte index resets to 0 and the address is latched.
- IDLE → RDATA on a read command. The addressed pending register is latched into a 32-bit read shift register. tx_byte = bits[31:24] with tx_load.
- In RDATA, each rx_valid (dummy byte, contents ignored) advances the index. After rx_valid number i (i = 1..3), tx_byte = byte i with tx_load. After the 4th rx_valid → DONE.
- In WDATA, each rx_valid shifts rx_byte into the assembly register. On the 4th byte:
  - the assembled word is written to pending[addr];
  - dirty[addr] is set;
  - state → DONE.
- An address ≥ NUM_REGS on the command byte → IGNORE and err_count += 1.
- DONE and IGNORE consume further bytes without effect or error.
- cs_n high in any non-IDLE state → IDLE on the next edge.
  - If the state was WDATA or RDATA (frame incomplete), err_count += 1.
  - An incomplete write never modifies pending.
- rx_valid while cs_n is high is ignored.
- SHADOW=1:
  - On frame_sync, active[k] ← pending[k] and dirty[k] clears for every dirty k.
  - cfg_update pulses once if any register was dirty.
- SHADOW=0:
  - active[k] is written together with pending[k].
  - cfg_update pulses for that commit.
- Read-back returns pending values, not active values.
- err_count saturates at 255 and never wraps.

## Timing
- Reset:
  - state = IDLE.
  - All pending, active, dirty, assembly and read registers = 0.
  - cfg_out = 0, tx_byte = 0, tx_load = 0, cfg_update = 0, busy = 0, err_count = 0.
- Reset asserted mid-frame discards the frame without incrementing err_count.
- All outputs are registered.
- Latency from an rx_valid at edge n: the state change, tx_byte/tx_load, or pending write is visible after edge n+1.
- tx_load and cfg_update are high for exactly one cycle.
- SHADOW=0: cfg_out changes on the same edge as the pending write. cfg_update is high during the cycle following that edge.
- SHADOW=1: cfg_out changes on the edge after frame_sync is sampled high. cfg_update is high for the following cycle.
- Commit and frame_sync on the same cycle: the copy uses pending and dirty as they were before that edge. The new write stays dirty and applies at the next frame_sync.
- cs_n rising on the same cycle as the 4th data byte: the commit completes, the state then goes to IDLE, and there is no error.
- Back-to-back frames: a new command is accepted on the first rx_valid after returning to IDLE (cs_n must go high between frames).

## Test plan
- Write, SHADOW=1:
  - Stimulus: cs_n low; bytes 0x80, 0xC0, 0x12, 0x34, 0x56; cs_n high.
  - Check: cfg_out[31:0] stays 0 until the next frame_sync.
  - Check: the edge after frame_sync gives 0xC0123456, with one cfg_update pulse.
- Read-back of the value above:
  - Stimulus: command 0x00, then 4 dummy bytes.
  - Check: tx_load pulses 4 times with tx_byte = 0xC0, 0x12, 0x34, 0x56; the 4th dummy byte produces no tx_load.
- Abort:
  - Stimulus: 0x81, 0xAA, 0xBB, then cs_n high.
  - Check: pending[1] unchanged (0), err_count = 1, busy low one cycle after cs_n rises.
- Invalid address (NUM_REGS=3):
  - Stimulus: command 0x83 followed by 4 bytes.
  - Check: no register changes, err_count += 1, no tx_load.
- Simultaneous events:
  - Stimulus: frame_sync on the same cycle as the 4th byte of a write to reg 2.
  - Check: cfg_out reg 2 is unchanged at that frame; it updates at the next frame_sync.
- SHADOW=0, plus saturation and reset:
  - Check: a write updates cfg_out one edge after the 4th byte.
  - Check: 260 aborted frames give err_count = 255.
  - Check: rst mid-write gives all outputs 0.
